// File: rtl/isqrt_pkg.sv
// Shared definitions for the integer square-root family: default operand
// width, FSM state encodings and a counter-width helper.
package isqrt_pkg;

    // Default root operand width
    localparam int ISQRT_W = 8;

    // FSM state encodings (2-bit, fixed values shared with the square-root block)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration counter width: ceil(log2(w)), never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/isqrt_recon_step.sv
// One reconstruction step: conditionally adds (root << idx) into the
// accumulator when bit idx of root is set. Purely combinational.
module isqrt_recon_step
    import isqrt_pkg::*;
#(
    parameter int W  = ISQRT_W,
    parameter int CW = cnt_width(ISQRT_W)
) (
    input  logic [2*W-1:0] acc_in,
    input  logic [W-1:0]   root,
    input  logic [CW-1:0]  idx,
    output logic [2*W-1:0] acc_out
);

    logic [2*W-1:0] root_ext;
    logic [2*W-1:0] addend;

    assign root_ext = {{W{1'b0}}, root};

    // Shift-add of a single root bit; the sum wraps modulo 2^(2W)
    always_comb begin
        addend  = root_ext << idx;
        acc_out = acc_in;
        if (root[idx]) begin
            acc_out = acc_in + addend;
        end
    end

endmodule

// File: rtl/isqrt_reconstruct.sv
// Reconstructs value = root^2 + rem from a square-root result by
// shift-and-add, one root bit per cycle (LSB first), and flags
// non-canonical remainders (rem > 2*root).
module isqrt_reconstruct
    import isqrt_pkg::*;
#(
    parameter int W = ISQRT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   root_in,
    input  logic [W:0]     rem_in,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] value_out,
    output logic           err
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]     state_reg;
    logic [W-1:0]   root_reg;
    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] acc_next;
    logic [CW-1:0]  cnt_reg;
    logic           err_reg;

    // The accumulator doubles as the capture register for the remainder:
    // it is loaded with rem_in at accept and only grows from there.
    isqrt_recon_step #(
        .W  (W),
        .CW (CW)
    ) u_step (
        .acc_in  (acc_reg),
        .root    (root_reg),
        .idx     (cnt_reg),
        .acc_out (acc_next)
    );

    // FSM, operand capture and accumulation; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            root_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        root_reg  <= root_in;
                        acc_reg   <= {{(W-1){1'b0}}, rem_in};
                        cnt_reg   <= '0;
                        err_reg   <= (rem_in > {root_in, 1'b0});
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_reg <= acc_next;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Handshake edge returns to IDLE; start is not looked at here,
                    // so a new accept can only happen on the following edge.
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign value_out = acc_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_isqrt_reconstruct.sv
// Directed self-checking bench for isqrt_reconstruct with a scoreboard queue.
module tb_isqrt_reconstruct;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  root_in;
    logic [8:0]  rem_in;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] value_out;
    logic        err;

    typedef struct {
        logic [15:0] v;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    isqrt_reconstruct #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .root_in   (root_in),
        .rem_in    (rem_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value_out (value_out),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One full transaction: accept, run, optional back-pressure, handshake
    task automatic run_op(input logic [7:0] r, input logic [8:0] m,
                          input bit hold_start, input int wait_cycles,
                          input bit start_on_hs);
        exp_t e;
        int   n;
        int   sq;
        start   = 1'b1;
        root_in = r;
        rem_in  = m;
        sq      = int'(r) * int'(r) + int'(m);
        e.v     = sq[15:0];
        e.e     = (int'(m) > 2 * int'(r));
        sb.push_back(e);
        tick();
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ov", 32'(out_valid), 32'd0);
        if (hold_start) begin
            root_in = ~r;
            rem_in  = ~m;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd8);
        start   = 1'b0;
        root_in = '0;
        rem_in  = '0;
        e = sb.pop_front();
        for (int i = 0; i < wait_cycles; i++) begin
            chk("hold_ov", 32'(out_valid), 32'd1);
            chk("hold_val", 32'(value_out), 32'(e.v));
            tick();
        end
        chk("value", 32'(value_out), 32'(e.v));
        chk("err", 32'(err), 32'(e.e));
        chk("done_ov", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        if (start_on_hs) begin
            start   = 1'b1;
            root_in = 8'd99;
            rem_in  = 9'd1;
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hs_ov", 32'(out_valid), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_val_held", 32'(value_out), 32'(e.v));
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        $display("txn root=%0d rem=%0d -> value=%0d err=%0d latency=%0d",
                 r, m, value_out, err, n);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        root_in   = '0;
        rem_in    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_val", 32'(value_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        run_op(8'd0,   9'd0,   1'b0, 0, 1'b0);
        run_op(8'd255, 9'd510, 1'b0, 0, 1'b0);
        run_op(8'd12,  9'd5,   1'b1, 0, 1'b0);
        run_op(8'd3,   9'd7,   1'b0, 0, 1'b0);
        run_op(8'd200, 9'd0,   1'b0, 5, 1'b1);

        // Reset in the middle of RUN abandons the operation
        start   = 1'b1;
        root_in = 8'd100;
        rem_in  = 9'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrun_busy", 32'(busy), 32'd1);
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_val", 32'(value_out), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_quiet", 32'(out_valid), 32'd0);
        end
        $display("txn reset mid-run -> abandoned");

        run_op(8'd7, 9'd3, 1'b0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
                   1'b0, i, 1'b0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isqrt_reconstruct.md
ISQRT_RECONSTRUCT -- requirements
Module: isqrt_reconstruct

Interface
REQ-001 SHALL have parameter W, default 8, root operand width; result width 2W, remainder width W+1.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a reconstruction.
REQ-005 SHALL have port root_in  input  W  integer square root operand.
REQ-006 SHALL have port rem_in  input  W+1  square-root remainder operand.
REQ-007 SHALL have port busy  output  1  high while not IDLE.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port value_out  output  2W  reconstructed value root^2 + rem.
REQ-011 SHALL have port err  output  1  remainder non-canonical (rem_in > 2*root_in).

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE; accept edge k captures root_in, rem_in into internal registers, loads accumulator with rem_in zero-extended to 2W, clears iteration counter, enters RUN.
REQ-014 SHALL ignore start and operand changes in RUN and DONE.
REQ-015 SHALL, per RUN cycle i (0..W-1), add (root << i) to accumulator when root bit i is 1, else hold accumulator; one bit per cycle, LSB first.
REQ-016 SHALL leave RUN for DONE on the edge where counter == W-1; out_valid first high after edge k+W (latency 8 for W=8).
REQ-017 SHALL compute value_out modulo 2^(2W); for canonical inputs no overflow occurs (255^2+510 = 65535).
REQ-018 SHALL set err at accept edge iff rem_in > 2*root_in (W+1-bit compare); err valid alongside out_valid and held until handshake.
REQ-019 SHALL hold out_valid, value_out, err stable in DONE until out_ready high on a rising edge; that edge returns FSM to IDLE.
REQ-020 SHALL not accept start in the same edge as the DONE->IDLE handshake; earliest new accept is the following edge.
REQ-021 SHALL keep value_out holding the last result after handshake until next accept; out_valid low outside DONE.
REQ-022 SHALL assert busy in RUN and DONE.

Reset
REQ-023 SHALL on rst high at a rising edge force IDLE, accumulator 0, counter 0, captured operands 0, err 0.
REQ-024 SHALL drive out_valid 0, busy 0, value_out 0, err 0 in the cycle after reset.
REQ-025 SHALL on reset mid-RUN or in DONE abandon the operation with no out_valid pulse; rst has priority over start and out_ready.

Structure
REQ-026 SHALL place state encodings (IDLE=0, RUN=1, DONE=2, 2-bit) and default W in shared package isqrt_pkg, reused by the square-root block.
REQ-027 SHALL use one sub-module, isqrt_recon_step: combinational conditional shift-add of one root bit into the accumulator.
REQ-028 SHALL size counter to ceil(log2(W)) bits, no other combinational outputs.

Verification
REQ-029 SHALL cover root=0, rem=0 -> value_out=0, err=0, out_valid 8 cycles after accept.
REQ-030 SHALL cover root=255, rem=510 -> value_out=65535, err=0.
REQ-031 SHALL cover root=12, rem=5 -> value_out=149, err=0; start held high during RUN causes no re-accept.
REQ-032 SHALL cover root=3, rem=7 -> value_out=16, err=1.
REQ-033 SHALL cover root=200, rem=0 with out_ready low 5 cycles -> value_out=40000 held stable, one handshake, then IDLE; start asserted on handshake edge not accepted.
REQ-034 SHALL cover rst pulse at RUN cycle 4 -> IDLE next cycle, no out_valid, next accept root=7, rem=3 -> 52.
